// File: rtl/veritune_freq_meter.sv
// Gated frequency counter for a 1-bit audio square wave: synchronise, deglitch,
// count filtered rising edges over a fixed window, then convert the count to BCD.
module veritune_freq_meter #(
  parameter int GATE_CYCLES = 5000000,
  parameter int FILT_LEN    = 4
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       En,
  input  logic       Mic,
  output logic [9:0] Freq_Cnt,
  output logic [3:0] Bcd3,
  output logic [3:0] Bcd2,
  output logic [3:0] Bcd1,
  output logic [3:0] Bcd0,
  output logic       Ovf,
  output logic       Valid,
  output logic       Busy
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam int RW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST   = RW'(FILT_LEN - 1);
  localparam logic [3:0]    ITER_LAST  = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GATE,
    S_CONVERT,
    S_PUBLISH
  } state_t;

  // Input conditioning
  logic          sync_q;
  logic          mic_s_q;
  logic          filt_q;
  logic          filt_d;
  logic [RW-1:0] run_q;
  logic [RW-1:0] run_d;
  logic          rise_d;
  logic          edge_q;

  // Measurement datapath
  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [9:0]    cnt_q;
  logic [9:0]    cnt_d;
  logic          sat_q;
  logic          sat_d;
  logic [9:0]    bin_q;
  logic [11:0]   bcd_q;
  logic [11:0]   bcd_adj;
  logic [12:0]   dd_step;
  logic [3:0]    iter_q;

  // Published results
  logic [9:0]    freq_q;
  logic          bcd3_q;
  logic [3:0]    bcd2_q;
  logic [3:0]    bcd1_q;
  logic [3:0]    bcd0_q;
  logic          ovf_q;
  logic          valid_q;
  logic          busy_q;

  // The level flips only once mic_s has disagreed for FILT_LEN cycles in a row.
  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    rise_d = 1'b0;
    if (mic_s_q != filt_q) begin
      if (run_q == RUN_LAST) begin
        filt_d = mic_s_q;
        rise_d = mic_s_q;
      end else begin
        run_d = run_q + RW'(1);
      end
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      sync_q  <= 1'b0;
      mic_s_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= '0;
      edge_q  <= 1'b0;
    end else begin
      sync_q  <= Mic;
      mic_s_q <= sync_q;
      filt_q  <= filt_d;
      run_q   <= run_d;
      edge_q  <= rise_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (edge_q) begin
      if (cnt_q == 10'd1023) begin
        sat_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 10'd1;
      end
    end
  end

  // Shift-add-3: only units..hundreds need correcting; thousands never exceeds 1.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign dd_step = {bcd_adj, bin_q[9]};

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      iter_q  <= '0;
      freq_q  <= '0;
      bcd3_q  <= 1'b0;
      bcd2_q  <= '0;
      bcd1_q  <= '0;
      bcd0_q  <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (En) begin
            state_q <= S_GATE;
            timer_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end

        S_GATE: begin
          if (!En) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_d;
            sat_q <= sat_d;
            if (timer_q == TIMER_LAST) begin
              // cnt_d already includes a pulse landing on the final gate cycle.
              state_q <= S_CONVERT;
              bin_q   <= cnt_d;
              bcd_q   <= '0;
              iter_q  <= '0;
            end else begin
              timer_q <= timer_q + TW'(1);
            end
          end
        end

        S_CONVERT: begin
          bin_q  <= {bin_q[8:0], 1'b0};
          bcd_q  <= dd_step[11:0];
          iter_q <= iter_q + 4'd1;
          if (iter_q == ITER_LAST) begin
            state_q <= S_PUBLISH;
            freq_q  <= cnt_q;
            bcd3_q  <= dd_step[12];
            bcd2_q  <= dd_step[11:8];
            bcd1_q  <= dd_step[7:4];
            bcd0_q  <= dd_step[3:0];
            ovf_q   <= sat_q;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end

        S_PUBLISH: begin
          valid_q <= 1'b0;
          if (En) begin
            state_q <= S_GATE;
            timer_q <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Freq_Cnt = freq_q;
  assign Bcd3     = {3'b000, bcd3_q};
  assign Bcd2     = bcd2_q;
  assign Bcd1     = bcd1_q;
  assign Bcd0     = bcd0_q;
  assign Ovf      = ovf_q;
  assign Valid    = valid_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_veritune_freq_meter.sv
// Bench for veritune_freq_meter: random Mic patterns, edge counts predicted from
// the recorded Mic history with a sliding-window deglitch rule.
module tb_veritune_freq_meter;

  localparam int G  = 1000;
  localparam int G2 = 20000;
  localparam int F  = 4;
  localparam int MAXC = 65536;

  logic board_clk = 1'b0;
  logic Reset = 1'b1;
  logic En = 1'b0;
  logic En2 = 1'b0;
  logic Mic = 1'b0;

  logic [9:0] Freq_Cnt, Freq_Cnt2;
  logic [3:0] Bcd3, Bcd2, Bcd1, Bcd0;
  logic [3:0] Bcd3_2, Bcd2_2, Bcd1_2, Bcd0_2;
  logic       Ovf, Valid, Busy;
  logic       Ovf2, Valid2, Busy2;

  veritune_freq_meter #(.GATE_CYCLES(G), .FILT_LEN(F)) dut (
    .board_clk(board_clk), .Reset(Reset), .En(En), .Mic(Mic),
    .Freq_Cnt(Freq_Cnt), .Bcd3(Bcd3), .Bcd2(Bcd2), .Bcd1(Bcd1), .Bcd0(Bcd0),
    .Ovf(Ovf), .Valid(Valid), .Busy(Busy)
  );

  veritune_freq_meter #(.GATE_CYCLES(G2), .FILT_LEN(F)) dut2 (
    .board_clk(board_clk), .Reset(Reset), .En(En2), .Mic(Mic),
    .Freq_Cnt(Freq_Cnt2), .Bcd3(Bcd3_2), .Bcd2(Bcd2_2), .Bcd1(Bcd1_2), .Bcd0(Bcd0_2),
    .Ovf(Ovf2), .Valid(Valid2), .Busy(Busy2)
  );

  always #5 board_clk = ~board_clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mic_hist [0:MAXC-1];
  int mic_mode = 0;
  int hi_len = 20;
  int lo_len = 20;
  int ph = 0;
  int seg_left = 0;
  bit noisy_lvl = 1'b0;
  int gate_start = 0;
  int saved_cnt = 0;

  // mic_hist[n] is the Mic level during cycle n (as sampled at its closing edge).
  always @(posedge board_clk) begin
    if (cyc < MAXC) mic_hist[cyc] <= Mic;
    cyc <= cyc + 1;
  end

  // Filtered level f[n] flips when the synchronised samples of the previous F
  // cycles (Mic delayed two cycles) all disagree with f[n-1]; a count is taken
  // for every cycle in the window where f rises.
  function automatic int model_edges(input int t, input int g);
    bit f_prev, f_cur, all_diff, sb;
    int cnt;
    cnt = 0;
    f_prev = 1'b0;
    for (int n = 1; n < t + g; n++) begin
      all_diff = 1'b1;
      for (int k = n - F; k < n; k++) begin
        sb = (k >= 2) ? mic_hist[k-2] : 1'b0;
        if (sb == f_prev) all_diff = 1'b0;
      end
      f_cur = all_diff ? ~f_prev : f_prev;
      if (n >= t && f_cur && !f_prev) cnt++;
      f_prev = f_cur;
    end
    return cnt;
  endfunction

  function automatic logic [15:0] digits(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic mic_driver();
    forever begin
      @(negedge board_clk);
      case (mic_mode)
        1: begin
          Mic = (ph < hi_len);
          ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
        end
        2: begin
          Mic = (ph < 2);
          ph = (ph + 1 >= 50) ? 0 : ph + 1;
        end
        3: begin
          if (seg_left == 0) begin
            noisy_lvl = ~noisy_lvl;
            seg_left = $urandom_range(1, 25);
          end
          Mic = noisy_lvl;
          seg_left--;
        end
        default: ;
      endcase
    end
  endtask

  task automatic wait_valid(input bit second, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge board_clk);
      if ((second ? Valid2 : Valid) === 1'b1) begin
        at = cyc;
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge board_clk);
    checks++; if (Freq_Cnt !== 10'd0) begin errors++; $display("FAIL reset_freq: got %0d expected 0", Freq_Cnt); end
    checks++; if ({Bcd3, Bcd2, Bcd1, Bcd0} !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", {Bcd3, Bcd2, Bcd1, Bcd0}); end
    checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", Ovf); end
    checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", Valid); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    checks++; if (Freq_Cnt2 !== 10'd0 || Ovf2 !== 1'b0) begin errors++; $display("FAIL reset_dut2: got cnt %0d ovf %b expected 0 0", Freq_Cnt2, Ovf2); end
    Reset = 1'b0;
    repeat (5) @(negedge board_clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", Busy); end
    $display("reset: outputs cleared, idle with En low");
  endtask

  task automatic test_square();
    int t, at, exp;
    hi_len = 20; lo_len = 20; ph = 0; mic_mode = 1;
    repeat (60) @(negedge board_clk);
    En = 1'b1;
    t = cyc + 1;
    @(negedge board_clk);
    checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL square_busy: got %b expected 1", Busy); end
    for (int k = 0; k < 2; k++) begin
      wait_valid(1'b0, 1200, at);
      exp = model_edges(t, G);
      checks++; if (at != t + G + 10) begin errors++; $display("FAIL square_latency: got cycle %0d expected %0d", at, t + G + 10); end
      checks++; if (Freq_Cnt !== 10'(exp)) begin errors++; $display("FAIL square_model: got %0d expected %0d", Freq_Cnt, exp); end
      checks++; if (Freq_Cnt !== 10'd25) begin errors++; $display("FAIL square_25: got %0d expected 25", Freq_Cnt); end
      checks++; if ({Bcd3, Bcd2, Bcd1, Bcd0} !== 16'h0025) begin errors++; $display("FAIL square_bcd: got %h expected 0025", {Bcd3, Bcd2, Bcd1, Bcd0}); end
      checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL square_ovf: got %b expected 0", Ovf); end
      $display("square gate %0d: start %0d publish %0d count %0d", k, t, at, Freq_Cnt);
      @(negedge board_clk);
      checks++; if (Valid !== 1'b0) begin errors++; $display("FAIL square_valid_width: got %b expected 0", Valid); end
      saved_cnt = exp;
      t = t + G + 11;
    end
    gate_start = t;
  endtask

  task automatic test_abort();
    int vcount;
    while (cyc < gate_start + 500) @(negedge board_clk);
    En = 1'b0;
    @(negedge board_clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", Busy); end
    vcount = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge board_clk);
      if (Valid === 1'b1) vcount++;
    end
    checks++; if (vcount != 0) begin errors++; $display("FAIL abort_valid: got %0d pulses expected 0", vcount); end
    checks++; if (Freq_Cnt !== 10'(saved_cnt)) begin errors++; $display("FAIL abort_hold: got %0d expected %0d", Freq_Cnt, saved_cnt); end
    $display("abort: En dropped at gate cycle 500, result held at %0d", Freq_Cnt);
  endtask

  task automatic test_glitch();
    int t, at, exp;
    ph = 0; mic_mode = 2;
    repeat (60) @(negedge board_clk);
    En = 1'b1;
    t = cyc + 1;
    wait_valid(1'b0, 1200, at);
    En = 1'b0;
    exp = model_edges(t, G);
    checks++; if (at != t + G + 10) begin errors++; $display("FAIL glitch_valid: got cycle %0d expected %0d", at, t + G + 10); end
    checks++; if (Freq_Cnt !== 10'(exp) || Freq_Cnt !== 10'd0) begin errors++; $display("FAIL glitch_count: got %0d expected %0d", Freq_Cnt, exp); end
    checks++; if ({Bcd3, Bcd2, Bcd1, Bcd0} !== 16'h0000) begin errors++; $display("FAIL glitch_bcd: got %h expected 0000", {Bcd3, Bcd2, Bcd1, Bcd0}); end
    $display("glitch gate: publish %0d count %0d", at, Freq_Cnt);
    mic_mode = 0;
    Mic = 1'b0;
  endtask

  task automatic test_last_cycle();
    int t, at, exp, n0;
    int want [3] = '{1, 1, 0};
    mic_mode = 0;
    for (int k = 0; k < 3; k++) begin
      Mic = 1'b0;
      repeat (20) @(negedge board_clk);
      En = 1'b1;
      t = cyc + 1;
      n0 = t + G - 8 + k;
      while (cyc < n0) @(negedge board_clk);
      Mic = 1'b1;
      while (cyc < t + G + 2) @(negedge board_clk);
      En = 1'b0;
      wait_valid(1'b0, 50, at);
      exp = model_edges(t, G);
      checks++; if (at != t + G + 10) begin errors++; $display("FAIL edge_pos_valid: got cycle %0d expected %0d", at, t + G + 10); end
      checks++; if (Freq_Cnt !== 10'(exp)) begin errors++; $display("FAIL edge_pos_model: got %0d expected %0d", Freq_Cnt, exp); end
      checks++; if (Freq_Cnt !== 10'(want[k])) begin errors++; $display("FAIL edge_pos_%0d: got %0d expected %0d", k, Freq_Cnt, want[k]); end
      $display("edge at gate cycle %0d: count %0d", G - 2 + k, Freq_Cnt);
    end
    Mic = 1'b0;
  endtask

  task automatic test_random();
    int t, at, exp;
    hi_len = $urandom_range(F, 30); lo_len = $urandom_range(F, 30); ph = 0; mic_mode = 1;
    repeat (80) @(negedge board_clk);
    En = 1'b1;
    t = cyc + 1;
    for (int r = 0; r < 4; r++) begin
      wait_valid(1'b0, 1200, at);
      if (r == 3) En = 1'b0;
      exp = model_edges(t, G);
      checks++; if (at != t + G + 10) begin errors++; $display("FAIL random_latency: got cycle %0d expected %0d", at, t + G + 10); end
      checks++; if (Freq_Cnt !== 10'(exp)) begin errors++; $display("FAIL random_count: got %0d expected %0d", Freq_Cnt, exp); end
      checks++; if ({Bcd3, Bcd2, Bcd1, Bcd0} !== digits(exp)) begin errors++; $display("FAIL random_bcd: got %h expected %h", {Bcd3, Bcd2, Bcd1, Bcd0}, digits(exp)); end
      checks++; if (Ovf !== 1'b0) begin errors++; $display("FAIL random_ovf: got %b expected 0", Ovf); end
      $display("random gate %0d: mode %0d hi %0d lo %0d count %0d", r, mic_mode, hi_len, lo_len, Freq_Cnt);
      if (r[0] == 1'b0) begin
        mic_mode = 3;
      end else begin
        hi_len = $urandom_range(F, 30); lo_len = $urandom_range(F, 30); ph = 0; mic_mode = 1;
      end
      t = t + G + 11;
    end
    @(negedge board_clk);
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL random_stop_busy: got %b expected 0", Busy); end
    mic_mode = 0;
    Mic = 1'b0;
  endtask

  task automatic test_reset_convert();
    int t, at, exp, c2;
    mic_mode = 0;
    Mic = 1'b0;
    repeat (40) @(negedge board_clk);
    En = 1'b1;
    t = cyc + 1;
    while (cyc < t + G + 3) @(negedge board_clk);
    Reset = 1'b1;
    En = 1'b0;
    #1;
    checks++; if (Freq_Cnt !== 10'd0) begin errors++; $display("FAIL rstconv_freq: got %0d expected 0", Freq_Cnt); end
    checks++; if ({Bcd3, Bcd2, Bcd1, Bcd0} !== 16'h0) begin errors++; $display("FAIL rstconv_bcd: got %h expected 0000", {Bcd3, Bcd2, Bcd1, Bcd0}); end
    checks++; if (Ovf !== 1'b0 || Valid !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL rstconv_flags: got ovf %b valid %b busy %b expected 0 0 0", Ovf, Valid, Busy); end
    repeat (3) @(negedge board_clk);
    Reset = 1'b0;
    repeat (5) @(negedge board_clk);
    En = 1'b1;
    c2 = cyc;
    wait_valid(1'b0, 1100, at);
    En = 1'b0;
    exp = model_edges(c2 + 1, G);
    checks++; if (at != c2 + 1011) begin errors++; $display("FAIL rstconv_valid: got cycle %0d expected %0d", at, c2 + 1011); end
    checks++; if (Freq_Cnt !== 10'(exp)) begin errors++; $display("FAIL rstconv_count: got %0d expected %0d", Freq_Cnt, exp); end
    $display("reset in convert: next publish at %0d count %0d", at, Freq_Cnt);
  endtask

  task automatic test_saturate();
    int t, at, exp, cap;
    hi_len = 5; lo_len = 5; ph = 0; mic_mode = 1;
    repeat (30) @(negedge board_clk);
    En2 = 1'b1;
    t = cyc + 1;
    @(negedge board_clk);
    checks++; if (Busy2 !== 1'b1) begin errors++; $display("FAIL sat_busy: got %b expected 1", Busy2); end
    wait_valid(1'b1, G2 + 100, at);
    En2 = 1'b0;
    exp = model_edges(t, G2);
    cap = (exp > 1023) ? 1023 : exp;
    checks++; if (at != t + G2 + 10) begin errors++; $display("FAIL sat_latency: got cycle %0d expected %0d", at, t + G2 + 10); end
    checks++; if (Freq_Cnt2 !== 10'(cap) || Freq_Cnt2 !== 10'd1023) begin errors++; $display("FAIL sat_count: got %0d expected %0d", Freq_Cnt2, cap); end
    checks++; if (Ovf2 !== (exp > 1023)) begin errors++; $display("FAIL sat_ovf: got %b expected %b", Ovf2, exp > 1023); end
    checks++; if ({Bcd3_2, Bcd2_2, Bcd1_2, Bcd0_2} !== 16'h1023) begin errors++; $display("FAIL sat_bcd: got %h expected 1023", {Bcd3_2, Bcd2_2, Bcd1_2, Bcd0_2}); end
    $display("saturate gate: raw edges %0d published %0d ovf %b", exp, Freq_Cnt2, Ovf2);
    mic_mode = 0;
  endtask

  initial begin
    fork
      mic_driver();
    join_none
    test_reset();
    test_square();
    test_abort();
    test_glitch();
    test_last_cycle();
    test_random();
    test_reset_convert();
    test_saturate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/veritune_freq_meter.md
VERITUNE_FREQ_METER -- requirements
Module: veritune_freq_meter

Interface
REQ-001 Parameter GATE_CYCLES, default 5000000, gate window length in board_clk cycles (100 ms at 50 MHz).
REQ-002 Parameter FILT_LEN, default 4, consecutive agreeing samples required to change the filtered Mic level.
REQ-003 board_clk  input  1  system clock; all state on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high.
REQ-005 En  input  1  measurement enable; level-sensitive.
REQ-006 Mic  input  1  asynchronous 1-bit audio square wave.
REQ-007 Freq_Cnt  output  10  rising-edge count of the last completed gate, saturated at 1023.
REQ-008 Bcd3, Bcd2, Bcd1, Bcd0  output  4 each  decimal digits of Freq_Cnt (thousands..units), for direct SSD display.
REQ-009 Ovf  output  1  last completed gate saturated.
REQ-010 Valid  output  1  one-cycle pulse when new results are published.
REQ-011 Busy  output  1  high in GATE and CONVERT states.

Function
REQ-012 Mic shall pass through a 2-flop synchronizer (mic_s) before any other use.
REQ-013 Filtered level (reset 0) shall toggle only after mic_s differs from it for FILT_LEN consecutive cycles; any agreeing sample clears the run counter.
REQ-014 A rising edge of the filtered level shall generate a one-cycle edge pulse.
REQ-015 States IDLE, GATE, CONVERT, PUBLISH; IDLE->GATE when En=1, clearing gate timer, edge counter and saturation flag.
REQ-016 GATE shall last exactly GATE_CYCLES cycles (timer 0..GATE_CYCLES-1), then enter CONVERT.
REQ-017 Each edge pulse in GATE, including the pulse on the final gate cycle, shall increment the edge counter; the counter holds at 1023 and sets the saturation flag.
REQ-018 En=0 during GATE shall abort to IDLE on the next edge: no Valid, all outputs hold previous values.
REQ-019 CONVERT shall perform a 10-iteration shift-add-3 binary-to-BCD conversion, one iteration per cycle, exactly 10 cycles; En ignored.
REQ-020 PUBLISH (1 cycle) shall update Freq_Cnt, Bcd3..Bcd0 and Ovf together and assert Valid in the same cycle.
REQ-021 Latency: first GATE cycle t -> Valid and new outputs at cycle t+GATE_CYCLES+10.
REQ-022 From PUBLISH: En=1 -> GATE (continuous mode, 11-cycle dead time, edges not counted); En=0 -> IDLE.
REQ-023 Outputs shall change only in PUBLISH; Bcd3 shall be 0 or 1 by construction.

Reset
REQ-024 Reset shall force IDLE and clear Freq_Cnt, Bcd3..Bcd0, Ovf, Valid, Busy, filter, synchronizer and all counters to 0 asynchronously.
REQ-025 Reset mid-GATE or mid-CONVERT shall discard the partial result; no Valid after release until a full gate completes.
REQ-026 After release, the first measurement shall start on the first cycle with En=1.

Verification (GATE_CYCLES=1000, FILT_LEN=4 unless stated)
REQ-027 Mic 20 high/20 low, En=1 held -> Freq_Cnt=25, Bcd=0,0,2,5, Ovf=0, Valid exactly 1 cycle at t+1010, repeated every 1011 cycles.
REQ-028 Mic 2-cycle high glitches every 50 cycles -> Freq_Cnt=0, Bcd=0,0,0,0, Valid still pulses.
REQ-029 GATE_CYCLES=20000, Mic 5 high/5 low -> Freq_Cnt=1023, Ovf=1, Bcd=1,0,2,3.
REQ-030 Previous result 25 published, En dropped at gate cycle 500 -> no Valid, Freq_Cnt stays 25, Busy=0 next cycle.
REQ-031 Filtered rising edge timed on gate cycle 999 only -> Freq_Cnt=1.
REQ-032 Reset asserted during CONVERT -> all outputs 0 immediately; no Valid until 1011 cycles after En reasserted.
